// File: rtl/field_snapshot_readout.sv
// Double-buffered snapshot of one LBM lattice sweep (u_x, u_y, rho, u^2 per cell).
// The host reads the front bank with a fixed 2-cycle latency while the solver fills the back bank.
module field_snapshot_readout #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 12,
   parameter int NUM_CELLS  = 2500
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         frame_start,
   input  logic                         in_valid,
   input  logic signed [DATA_WIDTH-1:0] in_ux,
   input  logic signed [DATA_WIDTH-1:0] in_uy,
   input  logic signed [DATA_WIDTH-1:0] in_rho,
   input  logic signed [DATA_WIDTH-1:0] in_u2,
   input  logic [15:0]                  GPIOi,
   output logic signed [DATA_WIDTH-1:0] GPIOux,
   output logic signed [DATA_WIDTH-1:0] GPIOuy,
   output logic signed [DATA_WIDTH-1:0] GPIOrho,
   output logic signed [DATA_WIDTH-1:0] GPIOu2,
   output logic                         rd_valid,
   output logic                         addr_err,
   output logic                         frame_ready,
   output logic [31:0]                  frame_count,
   output logic [15:0]                  frames_dropped,
   output logic                         short_frame
);

   localparam int WORD_W = 4 * DATA_WIDTH;
   localparam int unsigned NUM_CELLS_U = NUM_CELLS;
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_CELLS - 1);

   typedef enum logic [1:0] {WAIT_SOF, FILL, SWAP_PEND} state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   state_t                  state_q;
   logic                    front_q;
   logic [ADDR_WIDTH-1:0]   wr_ptr_q;
   logic [ADDR_WIDTH-1:0]   wr_ptr_d;
   logic [ADDR_WIDTH-1:0]   wr_idx;
   logic                    wr_en;
   logic                    frame_ready_q;
   logic [31:0]             frame_count_q;
   logic [15:0]             frames_dropped_q;
   logic                    short_frame_q;

   logic [WORD_W-1:0]       mem [0:(2**(ADDR_WIDTH+1))-1];

   logic                    rd_vld_p1_q;
   logic [14:0]             rd_idx_p1_q;
   logic                    rd_bank_p1_q;
   logic                    rd_rdy_p1_q;
   logic                    rd_oob_p1;
   logic                    rd_vld_p2_q;
   logic                    rd_oob_p2_q;
   logic                    rd_zero_p2_q;
   logic [WORD_W-1:0]       rd_word_p2_q;

   // A frame_start coinciding with in_valid restarts the frame at cell 0.
   always_comb begin
      wr_idx   = frame_start ? '0 : wr_ptr_q;
      wr_ptr_d = wr_idx + 1'b1;
      wr_en    = (state_q == FILL) && in_valid;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q          <= WAIT_SOF;
         front_q          <= 1'b0;
         wr_ptr_q         <= '0;
         frame_ready_q    <= 1'b0;
         frame_count_q    <= '0;
         frames_dropped_q <= '0;
         short_frame_q    <= 1'b0;
      end else begin
         case (state_q)
            WAIT_SOF: begin
               if (frame_start) begin
                  wr_ptr_q <= '0;
                  state_q  <= FILL;
               end
            end
            FILL: begin
               if (frame_start && (wr_ptr_q != '0)) short_frame_q <= 1'b1;
               if (in_valid) begin
                  if (wr_idx == LAST_IDX) begin
                     wr_ptr_q <= '0;
                     state_q  <= SWAP_PEND;
                  end else begin
                     wr_ptr_q <= wr_ptr_d;
                  end
               end else if (frame_start) begin
                  wr_ptr_q <= '0;
               end
            end
            SWAP_PEND: begin
               if (frame_start) frames_dropped_q <= sat_inc16(frames_dropped_q);
               // Host lock: the swap waits until no read request is being presented.
               if (!GPIOi[15]) begin
                  front_q       <= ~front_q;
                  frame_ready_q <= 1'b1;
                  frame_count_q <= frame_count_q + 32'd1;
                  state_q       <= WAIT_SOF;
               end
            end
            default: state_q <= WAIT_SOF;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[{~front_q, wr_idx}] <= {in_ux, in_uy, in_rho, in_u2};
   end

   // ---- stage p1: capture request, bank and readiness together ----
   always_ff @(posedge clk) begin
      if (rst) rd_vld_p1_q <= 1'b0;
      else     rd_vld_p1_q <= GPIOi[15];
   end

   always_ff @(posedge clk) begin
      rd_idx_p1_q  <= GPIOi[14:0];
      rd_bank_p1_q <= front_q;
      rd_rdy_p1_q  <= frame_ready_q;
   end

   assign rd_oob_p1 = (32'(rd_idx_p1_q) >= NUM_CELLS_U);

   // ---- stage p2: RAM read and range check ----
   always_ff @(posedge clk) begin
      if (rst) rd_vld_p2_q <= 1'b0;
      else     rd_vld_p2_q <= rd_vld_p1_q;
   end

   always_ff @(posedge clk) begin
      rd_word_p2_q <= mem[{rd_bank_p1_q, rd_idx_p1_q[ADDR_WIDTH-1:0]}];
      rd_oob_p2_q  <= rd_oob_p1;
      rd_zero_p2_q <= rd_oob_p1 || !rd_rdy_p1_q;
   end

   // ---- output stage: GPIO data holds when no read returns ----
   always_ff @(posedge clk) begin
      if (rst) begin
         GPIOux   <= '0;
         GPIOuy   <= '0;
         GPIOrho  <= '0;
         GPIOu2   <= '0;
         rd_valid <= 1'b0;
         addr_err <= 1'b0;
      end else if (rd_vld_p2_q) begin
         rd_valid <= 1'b1;
         addr_err <= rd_oob_p2_q;
         if (rd_zero_p2_q) begin
            GPIOux  <= '0;
            GPIOuy  <= '0;
            GPIOrho <= '0;
            GPIOu2  <= '0;
         end else begin
            {GPIOux, GPIOuy, GPIOrho, GPIOu2} <= rd_word_p2_q;
         end
      end else begin
         rd_valid <= 1'b0;
         addr_err <= 1'b0;
      end
   end

   assign frame_ready    = frame_ready_q;
   assign frame_count    = frame_count_q;
   assign frames_dropped = frames_dropped_q;
   assign short_frame    = short_frame_q;

endmodule

// File: doc/field_snapshot_readout.md
Name: field_snapshot_readout

Overview:
- Downstream consumer of the pipelined LBM solver's per-cell macroscopic outputs (u_x, u_y, rho, u_squared).
- Captures one complete lattice sweep into a double-buffered snapshot memory and serves host pixel queries over the GPIO interface.
- Host reads therefore always see a coherent frame, never a half-updated one.
- Sits between the solver top level and the host/PS GPIO bridge.

Parameters:
- DATA_WIDTH, 16, width of each field value.
- ADDR_WIDTH, 12, cell-index width; bank depth is 2**ADDR_WIDTH.
- NUM_CELLS, 2500, cells per frame; must satisfy NUM_CELLS <= 2**ADDR_WIDTH.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- frame_start  in  1  one-cycle pulse marking the start of a solver sweep.
- in_valid  in  1  field values for the next cell are valid this cycle.
- in_ux, in_uy, in_rho, in_u2  in  DATA_WIDTH each  signed field values for the current cell.
- GPIOi  in  16  bit 15 is host_transmission; bits [14:0] are the requested cell index.
- GPIOux, GPIOuy, GPIOrho, GPIOu2  out  DATA_WIDTH each  signed read data.
- rd_valid  out  1  read data valid.
- addr_err  out  1  the returned read had an index >= NUM_CELLS.
- frame_ready  out  1  the front bank holds a complete frame.
- frame_count  out  32  number of completed bank swaps.
- frames_dropped  out  16  saturating count of frames discarded.
- short_frame  out  1  sticky: a frame_start arrived mid-fill.

Behaviour:
- Reset values:
  - State = WAIT_SOF, front bank = 0, wr_ptr = 0.
  - All outputs 0.
  - Memory contents are not reset.
- Storage:
  - One RAM of 2*2**ADDR_WIDTH words, 4*DATA_WIDTH bits each, with synchronous read and write.
  - Address = {bank, index}.
  - Writes go to the back bank (~front); reads go to the front bank.
- Write FSM:
  - WAIT_SOF: in_valid is ignored. On frame_start: wr_ptr = 0, go to FILL.
  - FILL:
    - Each in_valid writes {in_ux, in_uy, in_rho, in_u2} to back[wr_ptr], then wr_ptr++.
    - If in_valid arrives with wr_ptr == NUM_CELLS-1: write that cell, go to SWAP_PEND.
    - frame_start with wr_ptr != 0: set short_frame, discard the partial frame, set wr_ptr = 0, stay in FILL.
    - If frame_start and in_valid occur in the same cycle, the cell is written to index 0.
  - SWAP_PEND:
    - in_valid is ignored.
    - Each frame_start increments frames_dropped, saturating at 0xFFFF.
    - When GPIOi[15] == 0 on a clock edge: toggle front, set frame_ready = 1, frame_count++, go to WAIT_SOF.
    - While GPIOi[15] == 1 the swap is deferred indefinitely. This is the host lock.
- Read path:
  - Fixed latency of 2.
  - A request is sampled at edge N when GPIOi[15] == 1.
  - Index and front bank are registered together at edge N. A swap at edge N+1 does not affect an in-flight read.
  - At edge N+1 the RAM is read (or range-checked). GPIO outputs and rd_valid update at edge N+2.
  - If index >= NUM_CELLS or frame_ready == 0: all four outputs = 0, rd_valid = 1. addr_err = 1 only for index >= NUM_CELLS.
  - When GPIOi[15] == 0, rd_valid = 0 two cycles later and the GPIO outputs hold their last values.
  - Back-to-back requests are accepted every cycle.
- Reset mid-operation: all state returns to the reset values at the next edge. The partial frame is lost and frame_ready = 0.
- Arithmetic: field data is stored and returned bit-exact with no scaling. Counters wrap at 32 bits (frame_count) or saturate (frames_dropped).

Test Plan:
1. Reset, then frame_start, then 2500 in_valid cells with in_ux = index and in_rho = 0x1000. Then GPIOi = 0x8000|37. Required: after 2 cycles GPIOux = 37, GPIOrho = 0x1000, rd_valid = 1; frame_ready = 1; frame_count = 1.
2. Before any frame completes, GPIOi = 0x8005. Required: outputs 0, rd_valid = 1, addr_err = 0. Then GPIOi = 0x8000|2500. Required: outputs 0, addr_err = 1.
3. Hold GPIOi[15] = 1 while frame 2 (in_ux = index+100) completes, and issue 3 frame_starts during the lock. Required: reads of 10 still return 10; frames_dropped = 3. Release: swap on the next edge, a read of 10 returns 110, frame_count = 2.
4. Issue frame_start after 1200 cells, then a full 2500-cell frame. Required: short_frame = 1; frame_count increments once; data matches the second frame only.
5. Issue a read with GPIOi[15] = 1 at cycle N and drop GPIOi[15] to 0 at N+1, while SWAP_PEND. Required: the read returns old-bank data at N+2; the swap occurs at edge N+1.
6. Assert rst during FILL at cell 800. Required: all outputs 0, frame_ready = 0, frame_count = 0 on the next cycle; a subsequent full frame completes normally.
